// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage
//  Purpose  : Pipeline memory stage. It holds the X/M register, sequences
//             data-memory accesses and produces the M/W writeback register.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_stage #(
    parameter int TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic        ex_load,
    input  logic        ex_store,
    input  logic        ex_byte,
    input  logic        ex_ubyte,
    input  logic        ex_dest,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_store_data,
    input  logic [4:0]  ex_rd,
    output logic        stall_out,
    output logic        mem_req,
    output logic        mem_wren,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        wb_valid,
    output logic        wb_dest,
    output logic        wb_fault,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic [4:0]  xm_rd,
    output logic        xm_dest
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_access = 2'd1;
    localparam logic [1:0] c_st_abort  = 2'd2;
    localparam logic [7:0] c_wait_last = 8'(TIMEOUT - 1);

    logic [1:0]  r_state;
    logic [7:0]  r_wait;
    logic        r_xm_valid;
    logic        r_xm_load;
    logic        r_xm_store;
    logic        r_xm_byte;
    logic        r_xm_ubyte;
    logic        r_xm_dest;
    logic [31:0] r_xm_addr;
    logic [31:0] r_xm_data;
    logic [4:0]  r_xm_rd;

    logic        w_ex_access;
    logic        w_xm_mem;
    logic        w_xm_byte;
    logic [7:0]  w_rd_byte;
    logic [31:0] w_load_data;

    // A ubyte load is a byte access too; only word accesses can be misaligned.
    assign w_ex_access = ex_valid && (ex_load || ex_store) &&
                         ((ex_byte || ex_ubyte) || (ex_addr[1:0] == 2'b00));
    assign w_xm_mem    = r_xm_load || r_xm_store;
    assign w_xm_byte   = r_xm_byte || r_xm_ubyte;

    always_comb begin
        stall_out = 1'b0;
        case (r_state)
            c_st_access: stall_out = !mem_ready;
            c_st_abort:  stall_out = 1'b1;
            default:     stall_out = 1'b0;
        endcase
    end

    assign mem_req   = (r_state == c_st_access);
    assign mem_wren  = mem_req && r_xm_store;
    assign mem_addr  = {r_xm_addr[31:2], 2'b00};
    assign mem_wdata = w_xm_byte ? {4{r_xm_data[7:0]}} : r_xm_data;
    // Byte offset 0 is the most significant byte lane.
    assign mem_be    = w_xm_byte ? (4'b1000 >> r_xm_addr[1:0]) : 4'b1111;

    assign xm_rd     = r_xm_rd;
    assign xm_dest   = r_xm_valid && r_xm_dest && !r_xm_load;

    always_comb begin
        w_rd_byte = 8'h00;
        case (r_xm_addr[1:0])
            2'd0:    w_rd_byte = mem_rdata[31:24];
            2'd1:    w_rd_byte = mem_rdata[23:16];
            2'd2:    w_rd_byte = mem_rdata[15:8];
            default: w_rd_byte = mem_rdata[7:0];
        endcase
        if (w_xm_byte)
            w_load_data = r_xm_ubyte ? {24'h000000, w_rd_byte} : {{24{w_rd_byte[7]}}, w_rd_byte};
        else
            w_load_data = mem_rdata;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= c_st_idle;
            r_wait     <= 8'd0;
            r_xm_valid <= 1'b0;
            wb_valid   <= 1'b0;
            wb_dest    <= 1'b0;
            wb_fault   <= 1'b0;
            wb_data    <= 32'd0;
            wb_rd      <= 5'd0;
        end else begin
            wb_valid <= 1'b0;
            wb_dest  <= 1'b0;
            wb_fault <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    // A memory op left in IDLE is a misaligned word access.
                    if (r_xm_valid) begin
                        wb_valid <= 1'b1;
                        wb_rd    <= r_xm_rd;
                        wb_data  <= r_xm_addr;
                        wb_fault <= w_xm_mem;
                        wb_dest  <= r_xm_dest && !w_xm_mem;
                    end
                end
                c_st_access: begin
                    if (mem_ready) begin
                        wb_valid <= 1'b1;
                        wb_rd    <= r_xm_rd;
                        wb_data  <= r_xm_load ? w_load_data : r_xm_addr;
                        wb_dest  <= r_xm_dest;
                    end else if (r_wait == c_wait_last) begin
                        r_state <= c_st_abort;
                    end else begin
                        r_wait <= r_wait + 8'd1;
                    end
                end
                c_st_abort: begin
                    wb_valid   <= 1'b1;
                    wb_fault   <= 1'b1;
                    wb_rd      <= r_xm_rd;
                    wb_data    <= r_xm_addr;
                    r_xm_valid <= 1'b0;
                    r_state    <= c_st_idle;
                end
                default: r_state <= c_st_idle;
            endcase

            if (!stall_out) begin
                r_xm_valid <= ex_valid;
                r_xm_load  <= ex_valid && ex_load;
                r_xm_store <= ex_valid && ex_store;
                r_xm_byte  <= ex_byte;
                r_xm_ubyte <= ex_ubyte;
                r_xm_dest  <= ex_dest;
                r_xm_addr  <= ex_addr;
                r_xm_data  <= ex_store_data;
                r_xm_rd    <= ex_rd;
                r_wait     <= 8'd0;
                r_state    <= w_ex_access ? c_st_access : c_st_idle;
            end
        end
    end

endmodule
`default_nettype wire
